// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to the instruction RAM and
// buffers {pc, inst} pairs in a 2-entry queue toward decode.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] inst_addr,
    output logic        inst_en,
    input  logic [31:0] inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    localparam logic [1:0] FULL = 2'(QDEPTH);

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [1:0]  count;
    logic        head;
    logic        tail;

    logic [63:0] q_pc    [2];
    logic [31:0] q_inst  [2];
    logic        q_fault [2];

    logic aligned;
    logic push;
    logic fault_push;
    logic pop;

    // A push happens every cycle there is room, unless stalled by fault/redirect/reset;
    // a misaligned PC turns that push into a fault marker instead of a fetch.
    assign aligned    = (pc[1:0] == 2'b00);
    assign push       = (state == RUN) && (count != FULL) && !redirect_valid && !rst;
    assign inst_en    = push && aligned;
    assign fault_push = push && !aligned;
    assign inst_addr  = pc;

    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign out_pc     = out_valid ? q_pc[head]    : 64'h0;
    assign out_inst   = out_valid ? q_inst[head]  : 32'h0;
    assign out_fault  = out_valid ? q_fault[head] : 1'b0;

    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else if (fault_push) begin
            state_next = FAULT;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (inst_en) begin
                pc <= pc + 64'd4;
            end
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: queue storage is not reset; entries are only observable through
    // count, and the head fields are masked to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= pc;
            q_inst[tail]  <= aligned ? inst : 32'h0;
            q_fault[tail] <= !aligned;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] inst_addr;
    logic        inst_en;
    logic [31:0] inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr      (inst_addr),
        .inst_en        (inst_en),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    function automatic logic [31:0] ram_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    assign inst = ram_word(inst_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of fetched entries plus the next fetch address.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    bit          m_faulted = 1'b0;
    bit          m_init    = 1'b0;

    task automatic model_step();
        int n;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pc      = RESET_PC;
            m_faulted = 1'b0;
            m_init    = 1'b1;
        end else if (m_init) begin
            if (redirect_valid) begin
                mq.delete();
                m_pc      = redirect_pc;
                m_faulted = 1'b0;
            end else begin
                n = mq.size();
                if (n > 0 && out_ready) void'(mq.pop_front());
                if (!m_faulted && n < 2) begin
                    e.pc = m_pc;
                    if (m_pc % 4 == 0) begin
                        e.inst  = ram_word(m_pc);
                        e.fault = 1'b0;
                        m_pc    = m_pc + 64'd4;
                    end else begin
                        e.inst    = 32'h0;
                        e.fault   = 1'b1;
                        m_faulted = 1'b1;
                    end
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic model_check();
        logic exp_en;
        if (!m_init) return;
        exp_en = !rst && !redirect_valid && !m_faulted && (mq.size() < 2) && (m_pc % 4 == 0);
        check("model_inst_en", inst_en, exp_en);
        check("model_inst_addr", inst_addr, m_pc);
        check("model_out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("model_out_pc", out_pc, mq[0].pc);
            check("model_out_inst", out_inst, mq[0].inst);
            check("model_out_fault", out_fault, mq[0].fault);
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        e_valid;
        logic        e_en;
        logic [63:0] e_addr;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic v, input logic en,
                                input logic [63:0] addr, input logic [63:0] hp, input logic [31:0] hi);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.e_valid = v; t.e_en = en;
        t.e_addr = addr; t.e_pc = hp; t.e_inst = hi;
        return t;
    endfunction

    vec_t vecs[9];

    initial begin
        logic [63:0] rpc;

        // Back-pressure from reset: two pushes, stall, then in-order drain and resume.
        vecs[0] = mk(1, 0, 0, 0, 64'h8000_0000, 64'h0, 32'h0);
        vecs[1] = mk(0, 0, 0, 1, 64'h8000_0000, 64'h0, 32'h0);
        vecs[2] = mk(0, 0, 1, 1, 64'h8000_0004, 64'h8000_0000, 32'h0000_0013);
        vecs[3] = mk(0, 0, 1, 0, 64'h8000_0008, 64'h8000_0000, 32'h0000_0013);
        vecs[4] = mk(0, 0, 1, 0, 64'h8000_0008, 64'h8000_0000, 32'h0000_0013);
        vecs[5] = mk(0, 1, 1, 0, 64'h8000_0008, 64'h8000_0000, 32'h0000_0013);
        vecs[6] = mk(0, 1, 1, 1, 64'h8000_0008, 64'h8000_0004, 32'h0010_0093);
        vecs[7] = mk(0, 1, 1, 1, 64'h8000_000C, 64'h8000_0008, ram_word(64'h8000_0008));
        vecs[8] = mk(0, 1, 1, 1, 64'h8000_0010, 64'h8000_000C, ram_word(64'h8000_000C));

        drive(1, 0, 64'h0, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst, 0, 64'h0, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_en", i), inst_en, vecs[i].e_en);
            check($sformatf("vec%0d_addr", i), inst_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
            check($sformatf("vec%0d_inst", i), out_inst, vecs[i].e_inst);
            check($sformatf("vec%0d_fault", i), out_fault, 64'h0);
            tick();
        end

        // Reset release with out_ready high: no bubbles, one-cycle fill latency.
        drive(1, 0, 64'h0, 1);
        tick();
        drive(0, 0, 64'h0, 1);
        check("rel_en", inst_en, 1);
        check("rel_valid", out_valid, 0);
        tick();
        drive(0, 0, 64'h0, 1);
        check("rel_pc0", out_pc, 64'h8000_0000);
        check("rel_inst0", out_inst, 32'h0000_0013);
        check("rel_addr1", inst_addr, 64'h8000_0004);
        tick();
        drive(0, 0, 64'h0, 1);
        check("rel_pc1", out_pc, 64'h8000_0004);
        check("rel_inst1", out_inst, 32'h0010_0093);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 64'h0, 1);
            check("steady_valid", out_valid, 1);
            check("steady_pc", out_pc, 64'h8000_0008 + 64'(4 * i));
            tick();
        end

        // Redirect with two entries queued: queued entries vanish.
        drive(0, 0, 64'h0, 0);
        tick();
        drive(0, 1, 64'h8000_1000, 1);
        check("full_en", inst_en, 0);
        tick();
        drive(0, 0, 64'h0, 1);
        check("redir_valid", out_valid, 0);
        check("redir_addr", inst_addr, 64'h8000_1000);
        check("redir_en", inst_en, 1);
        tick();
        drive(0, 0, 64'h0, 1);
        check("redir_hpc", out_pc, 64'h8000_1000);
        check("redir_hinst", out_inst, ram_word(64'h8000_1000));
        tick();

        // Misaligned redirect target: one fault marker, then silence until redirect.
        drive(0, 1, 64'h8000_0102, 1);
        tick();
        drive(0, 0, 64'h0, 1);
        check("mis_en", inst_en, 0);
        check("mis_valid0", out_valid, 0);
        tick();
        drive(0, 0, 64'h0, 1);
        check("mis_valid", out_valid, 1);
        check("mis_fault", out_fault, 1);
        check("mis_pc", out_pc, 64'h8000_0102);
        check("mis_inst", out_inst, 32'h0);
        check("mis_en2", inst_en, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 64'h0, 1);
            check("flt_valid", out_valid, 0);
            check("flt_en", inst_en, 0);
            tick();
        end
        drive(0, 1, 64'h8000_0200, 1);
        tick();
        drive(0, 0, 64'h0, 1);
        check("resume_en", inst_en, 1);
        check("resume_addr", inst_addr, 64'h8000_0200);
        tick();
        drive(0, 0, 64'h0, 1);
        check("resume_pc", out_pc, 64'h8000_0200);
        check("resume_fault", out_fault, 0);

        // Reset with full queue and concurrent redirect: reset wins.
        drive(0, 0, 64'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0);
        check("pre_rst_full", inst_en, 0);
        check("pre_rst_valid", out_valid, 1);
        drive(1, 1, 64'h8000_1000, 1);
        check("rst_en", inst_en, 0);
        tick();
        drive(0, 0, 64'h0, 1);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_addr", inst_addr, 64'h8000_0000);
        tick();
        drive(0, 0, 64'h0, 1);
        check("post_rst_pc", out_pc, 64'h8000_0000);
        check("post_rst_inst", out_inst, 32'h0000_0013);
        tick();

        // PC wraps modulo 2^64.
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        tick();
        drive(0, 0, 64'h0, 1);
        check("wrap_addr0", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(0, 0, 64'h0, 1);
        check("wrap_addr1", inst_addr, 64'h0);
        check("wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0:       rpc = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4 + 64'($urandom_range(1, 3));
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                default: rpc = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
            endcase
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, rpc, $urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
